// File: rtl/hdmi_led_dimmer.sv
// -----------------------------------------------------------------------------
// hdmi_led_dimmer
//
// Sits between the 8-bit LED PIO and the board LEDs. It registers the PIO
// pattern, applies a global PWM brightness, and blanks selected LEDs during
// the "off" half of a slow blink. The block is configured through a
// zero-wait-state Avalon-MM slave that shares the bus with the PIO.
//
// Register map (32-bit words, zero-extended on read):
//   0  DUTY[7:0]                 PWM duty; 00 = always off, FF = always on
//   1  BLINK_MASK[7:0]           LEDs that take part in blinking
//   2  BLINK_HALF[BLINK_W-1:0]   blink half-period in PWM periods, 0 = no blink
//   3  STATUS (read-only)        {23'b0, blink_phase, led_out[7:0]}
//
// Ports:
//   clk         system clock, single domain
//   reset_n     asynchronous active-low reset, synchronously released upstream
//   address     register select
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    combinational read data of the selected register
//   led_in      LED pattern from the PIO out_port
//   led_out     registered LED drive, 1 = lit
// -----------------------------------------------------------------------------
module hdmi_led_dimmer #(
  parameter int PWM_PRESCALE = 195,
  parameter int BLINK_W      = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  led_in,
  output logic [7:0]  led_out
);

  // A prescale of 1 still needs a 1-bit counter that simply stays at 0.
  localparam int PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [PRE_W-1:0]   PRE_LAST      = PRE_W'(PWM_PRESCALE - 1);
  localparam logic [BLINK_W-1:0] BLINK_HALF_RST = BLINK_W'(500);

  // Configuration registers
  logic [7:0]         duty;
  logic [7:0]         blink_mask;
  logic [BLINK_W-1:0] blink_half;

  // Timing chain
  logic [PRE_W-1:0]   pre_cnt;
  logic [7:0]         pwm_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic               tick;
  logic               period_end;
  logic               pwm_on;

  // LED datapath
  logic [7:0]         led_q;
  logic [7:0]         blink_kill;

  logic               wr_en;
  logic               wr_half;

  // Upper write-data bits have no destination; fold them into a dummy net.
  logic               unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_en   = chipselect & ~write_n;
  assign wr_half = wr_en && (address == 2'd2);

  // ---------------------------------------------------------------------------
  // Bus slave: register writes and combinational readback
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty       <= 8'hFF;
      blink_mask <= 8'h00;
      blink_half <= BLINK_HALF_RST;
    end else if (wr_en) begin
      case (address)
        2'd0:    duty       <= writedata[7:0];
        2'd1:    blink_mask <= writedata[7:0];
        2'd2:    blink_half <= writedata[BLINK_W-1:0];
        default: ;  // STATUS is read-only
      endcase
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = {24'd0, duty};
      2'd1:    readdata = {24'd0, blink_mask};
      2'd2:    readdata = 32'(blink_half);
      default: readdata = {23'd0, blink_phase, led_out};
    endcase
  end

  // ---------------------------------------------------------------------------
  // PWM timing: prescaler -> 8-bit PWM counter
  // ---------------------------------------------------------------------------
  assign tick       = (pre_cnt == PRE_LAST);
  assign period_end = tick && (pwm_cnt == 8'hFF);
  assign pwm_on     = (duty == 8'hFF) || (pwm_cnt < duty);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      pwm_cnt <= 8'd0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Blink timing: counts whole PWM periods, toggles phase every BLINK_HALF
  // ---------------------------------------------------------------------------
  // A write to BLINK_HALF restarts the half-period but keeps the current
  // phase, and wins over a coinciding period_end. A half-period of zero parks
  // the phase at 1 so masked LEDs stay lit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (wr_half) begin
      blink_cnt   <= '0;
    end else if (blink_half == '0) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (period_end) begin
      if (blink_cnt == blink_half - 1'b1) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: capture PIO pattern
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) led_q <= 8'd0;
    else          led_q <= led_in;
  end

  // ---------------------------------------------------------------------------
  // Stage 2: apply PWM gate and blink mask, drive the pins
  // ---------------------------------------------------------------------------
  assign blink_kill = blink_mask & {8{~blink_phase}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) led_out <= 8'd0;
    else          led_out <= led_q & {8{pwm_on}} & ~blink_kill;
  end

endmodule

// File: tb/tb_hdmi_led_dimmer.sv
// Bench for hdmi_led_dimmer. Two instances share the bus and LED input:
// u_p2 runs with a prescale of 2, u_p1 with a prescale of 1. Each has its own
// chipselect so configuration can be written to one of them at a time.
module tb_hdmi_led_dimmer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        cs2, cs1;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] rd2, rd1;
  logic [7:0]  led_in;
  logic [7:0]  lo2, lo1;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  hdmi_led_dimmer #(.PWM_PRESCALE(2), .BLINK_W(16)) u_p2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs2),
    .write_n(write_n), .writedata(writedata), .readdata(rd2),
    .led_in(led_in), .led_out(lo2)
  );

  hdmi_led_dimmer #(.PWM_PRESCALE(1), .BLINK_W(16)) u_p1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs1),
    .write_n(write_n), .writedata(writedata), .readdata(rd1),
    .led_in(led_in), .led_out(lo1)
  );

  typedef struct {
    string       name;
    logic        do_wr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // which: 0 -> u_p2, 1 -> u_p1
  task automatic wr(input logic which, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    cs2       = (which == 1'b0);
    cs1       = (which == 1'b1);
    @(posedge clk);
    #1;
    cs2     = 1'b0;
    cs1     = 1'b0;
    write_n = 1'b1;
  endtask

  function automatic logic [7:0] cur(input logic which);
    return which ? lo1 : lo2;
  endfunction

  // Returns at the first negedge where led_out switched from 'from' to 'to'.
  task automatic wait_for(input logic which, input logic [7:0] from, input logic [7:0] to,
                          input int budget, output logic ok);
    logic [7:0] prev;
    ok = 1'b0;
    @(negedge clk);
    prev = cur(which);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (prev == from && cur(which) == to) begin
        ok = 1'b1;
        break;
      end
      prev = cur(which);
    end
  endtask

  // Counts consecutive negedge samples equal to val; samples STATUS[8] mid-run.
  task automatic run_len(input logic which, input logic [7:0] val, output int n, output logic ph);
    n  = 0;
    ph = 1'bx;
    while (cur(which) == val && n < 2000) begin
      if (n == 100) ph = which ? rd1[8] : rd2[8];
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic ok;
    int   n;
    logic ph;
    int   bad;

    reset_n   = 1'b0;
    address   = 2'd0;
    cs2       = 1'b0;
    cs1       = 1'b0;
    write_n   = 1'b1;
    writedata = 32'd0;
    led_in    = 8'h00;

    vecs[0]  = '{"rst_duty",   1'b0, 2'd0, 32'h0,         2'd0, 32'h0000_00FF};
    vecs[1]  = '{"rst_mask",   1'b0, 2'd0, 32'h0,         2'd1, 32'h0000_0000};
    vecs[2]  = '{"rst_half",   1'b0, 2'd0, 32'h0,         2'd2, 32'h0000_01F4};
    vecs[3]  = '{"rst_status", 1'b0, 2'd0, 32'h0,         2'd3, 32'h0000_0100};
    vecs[4]  = '{"wr_duty",    1'b1, 2'd0, 32'h0000_0123, 2'd0, 32'h0000_0023};
    vecs[5]  = '{"wr_mask",    1'b1, 2'd1, 32'h0000_ABCD, 2'd1, 32'h0000_00CD};
    vecs[6]  = '{"wr_half",    1'b1, 2'd2, 32'h0001_2345, 2'd2, 32'h0000_2345};
    vecs[7]  = '{"ro_duty",    1'b1, 2'd3, 32'hFFFF_FFFF, 2'd0, 32'h0000_0023};
    vecs[8]  = '{"ro_mask",    1'b0, 2'd0, 32'h0,         2'd1, 32'h0000_00CD};
    vecs[9]  = '{"ro_half",    1'b0, 2'd0, 32'h0,         2'd2, 32'h0000_2345};
    vecs[10] = '{"ro_status",  1'b0, 2'd0, 32'h0,         2'd3, 32'h0000_0100};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_led_out", {24'd0, lo2}, 32'h0);

    // Register access vectors
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (vecs[i].do_wr) wr(1'b0, vecs[i].waddr, vecs[i].wdata);
      address = vecs[i].raddr;
      #1;
      chk(vecs[i].name, rd2, vecs[i].exp);
    end

    @(negedge clk);
    wr(1'b0, 2'd0, 32'hFF);
    wr(1'b0, 2'd1, 32'h00);
    wr(1'b0, 2'd2, 32'd500);

    // Two-cycle latency with full duty
    @(negedge clk);
    led_in = 8'hA5;
    @(negedge clk);
    chk("lat_1clk", {24'd0, lo2}, 32'h00);
    @(negedge clk);
    chk("lat_2clk", {24'd0, lo2}, 32'hA5);
    address = 2'd3;
    #1;
    chk("status_led", rd2, 32'h0000_01A5);

    // PWM at 50% duty, prescale 2: 256 clk on, 256 clk off
    @(negedge clk);
    wr(1'b0, 2'd0, 32'h80);
    led_in = 8'hFF;
    wait_for(1'b0, 8'h00, 8'hFF, 1500, ok);
    chk("pwm_edge_found", {31'd0, ok}, 32'd1);
    run_len(1'b0, 8'hFF, n, ph);
    chk("pwm_on_len", n, 32'd256);
    run_len(1'b0, 8'h00, n, ph);
    chk("pwm_off_len", n, 32'd256);
    run_len(1'b0, 8'hFF, n, ph);
    chk("pwm_on_len2", n, 32'd256);

    // Zero duty keeps the LEDs dark
    wr(1'b0, 2'd0, 32'h00);
    repeat (3) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (lo2 != 8'h00) bad++;
    end
    chk("duty0_dark", bad, 32'd0);

    // Blink on the prescale-1 instance: FF / F0 every 512 clk
    wr(1'b1, 2'd1, 32'h0F);
    wr(1'b1, 2'd0, 32'hFF);
    wr(1'b1, 2'd2, 32'd2);
    address = 2'd3;
    wait_for(1'b1, 8'hFF, 8'hF0, 3000, ok);
    chk("blink_edge_found", {31'd0, ok}, 32'd1);
    run_len(1'b1, 8'hF0, n, ph);
    chk("blink_off_len", n, 32'd512);
    chk("blink_phase0", {31'd0, ph}, 32'd0);
    run_len(1'b1, 8'hFF, n, ph);
    chk("blink_on_len", n, 32'd512);
    chk("blink_phase1", {31'd0, ph}, 32'd1);
    run_len(1'b1, 8'hF0, n, ph);
    chk("blink_off_len2", n, 32'd512);

    // BLINK_HALF = 0 stops blinking with masked LEDs lit
    wr(1'b1, 2'd2, 32'd0);
    repeat (3) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (lo1 != 8'hFF) bad++;
    end
    chk("half0_steady", bad, 32'd0);
    address = 2'd3;
    #1;
    chk("half0_phase", {31'd0, rd1[8]}, 32'd1);

    // Asynchronous reset mid-period
    @(negedge clk);
    wr(1'b0, 2'd0, 32'h80);
    wait_for(1'b0, 8'h00, 8'hFF, 1500, ok);
    repeat (40) @(negedge clk);
    chk("pre_rst_lit", {24'd0, lo2}, 32'hFF);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_p2", {24'd0, lo2}, 32'h00);
    chk("rst_async_p1", {24'd0, lo1}, 32'h00);
    @(negedge clk);
    reset_n = 1'b1;
    address = 2'd0;
    #1;
    chk("rerst_duty", rd2, 32'h0000_00FF);
    address = 2'd2;
    #1;
    chk("rerst_half", rd2, 32'h0000_01F4);
    address = 2'd3;
    #1;
    chk("rerst_status", rd2, 32'h0000_0100);
    @(negedge clk);
    chk("rerst_1clk", {24'd0, lo2}, 32'h00);
    @(negedge clk);
    chk("rerst_2clk", {24'd0, lo2}, 32'hFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
